// File: rtl/hack_pkg.sv
// hack_pkg -- shared definitions for the boot sequencer.
//   ROM_DEPTH / ROM_ADDR_W : instruction-ROM geometry (32K x 16)
//   HDR_BYTES              : bytes in the word-count header
//   boot_state_e           : sequencer state encoding
//   hdr_count_bad()        : header word-count legality test
package hack_pkg;

  localparam int unsigned ROM_DEPTH  = 32768;
  localparam int unsigned ROM_ADDR_W = $clog2(ROM_DEPTH);
  localparam int unsigned HDR_BYTES  = 2;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR_HI  = 4'd1,
    ST_HDR_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_HOLD    = 4'd6,
    ST_RUN     = 4'd7,
    ST_ERROR   = 4'd8
  } boot_state_e;

  // A zero-length image, or one larger than the ROM, cannot be loaded.
  function automatic logic hdr_count_bad(input logic [15:0] n, input int unsigned aw);
    return (n == 16'd0) || (32'(n) > (32'd1 << aw));
  endfunction

endpackage

// File: rtl/boot_sequencer.sv
// boot_sequencer -- loads a program image from a byte stream into the
// instruction ROM, then releases the CPU from reset.
//
// Byte stream: 16-bit word count N (high byte first), then N 16-bit words
// (high byte first). Each word is written to consecutive ROM addresses
// starting at 0; after the last write the CPU is held in reset for
// HOLD_CYCLES more cycles, then released.
//
// Ports
//   clk        in   system clock (rising edge)
//   rst        in   asynchronous active-high reset
//   boot_req   in   restart pulse, honoured in RUN and ERROR only
//   rx_data    in   program byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  byte accepted when rx_valid & rx_ready at a rising edge
//   rom_we     out  ROM write strobe, one cycle per word
//   rom_addr   out  ROM word address
//   rom_wdata  out  assembled 16-bit word
//   cpu_rst    out  CPU reset, low only in RUN
//   busy       out  load in progress (HDR_HI .. HOLD)
//   err        out  bad header seen (ERROR)
module boot_sequencer
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W      = ROM_ADDR_W,
  parameter int unsigned HOLD_CYCLES = 4           // must be >= 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              err
);

  localparam int unsigned       HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  boot_state_e       r_state;
  boot_state_e       w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [15:0]       r_cnt;    // header value, then words still to write
  logic [HOLD_W-1:0] r_hold;
  logic              w_hdr_bad;
  logic              w_more;

  // Judge the count using the low byte as it arrives so HDR_LO can branch
  // straight to ERROR or DATA_HI without an extra check state.
  assign w_hdr_bad = hdr_count_bad({r_cnt[15:8], rx_data}, ADDR_W);

  // In WRITE, r_cnt still includes the word being written.
  assign w_more = (r_cnt != 16'd1);

  assign rom_addr  = r_addr;
  assign rom_wdata = r_wdata;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state and Moore outputs
  always_comb begin
    w_next   = r_state;
    rx_ready = 1'b0;
    rom_we   = 1'b0;
    cpu_rst  = 1'b1;
    busy     = 1'b0;
    err      = 1'b0;
    case (r_state)
      ST_IDLE: w_next = ST_HDR_HI;
      ST_HDR_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) w_next = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) w_next = w_hdr_bad ? ST_ERROR : ST_DATA_HI;
      end
      ST_DATA_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) w_next = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        rom_we = 1'b1;
        busy   = 1'b1;
        w_next = w_more ? ST_DATA_HI : ST_HOLD;
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (r_hold == HOLD_LAST) w_next = ST_RUN;
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        if (boot_req) w_next = ST_HDR_HI;
      end
      ST_ERROR: begin
        err = 1'b1;
        if (boot_req) w_next = ST_HDR_HI;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: header count, byte assembly, address and hold counters.
  // rx_ready is high in every state that consumes rx_data below, so
  // rx_valid alone marks a transfer there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_IDLE:    r_addr <= '0;
        ST_HDR_HI:  if (rx_valid) r_cnt[15:8]   <= rx_data;
        ST_HDR_LO:  if (rx_valid) r_cnt[7:0]    <= rx_data;
        ST_DATA_HI: if (rx_valid) r_wdata[15:8] <= rx_data;
        ST_DATA_LO: if (rx_valid) r_wdata[7:0]  <= rx_data;
        ST_WRITE: begin
          r_cnt  <= r_cnt - 16'd1;
          r_hold <= '0;
          // Advance only when another word follows, so a full-ROM image
          // leaves the address on the last word instead of wrapping to 0.
          if (w_more) r_addr <= r_addr + ADDR_W'(1);
        end
        ST_HOLD: r_hold <= r_hold + HOLD_W'(1);
        ST_RUN, ST_ERROR: begin
          if (boot_req) begin
            r_addr <= '0;
            r_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
module tb_boot_sequencer;

  // A reduced ROM keeps the full-image boundary load short.
  localparam int AW   = 8;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          boot_req = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, rom_we, cpu_rst, busy, err;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int prev_we_cyc = 0;

  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] mon_e;

  boot_sequencer #(.ADDR_W(AW), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .boot_req  (boot_req),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every ROM write must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && rom_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rom_write_unexpected got addr=%0h data=%0h want no write", rom_addr, rom_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rom_addr, rom_wdata} !== mon_e) begin
          n_err++;
          $display("FAIL rom_write got addr=%0h data=%0h want addr=%0h data=%0h",
                   rom_addr, rom_wdata, mon_e[AW+15:16], mon_e[15:0]);
        end
      end
      prev_we_cyc = last_we_cyc;
      last_we_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---- drivers (all return 1 time unit after a rising edge) ----
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    do begin @(negedge clk); t++; end while (!rx_ready && t < 200);
    if (!rx_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_byte_timeout got rx_ready=%0b want 1", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n, input int mg);
    send_byte(n[15:8], mg ? $urandom_range(0, mg) : 0);
    send_byte(n[7:0],  mg ? $urandom_range(0, mg) : 0);
  endtask

  task automatic send_word(input int addr, input logic [15:0] d, input int mg);
    exp_q.push_back({AW'(addr), d});
    send_byte(d[15:8], mg ? $urandom_range(0, mg) : 0);
    send_byte(d[7:0],  mg ? $urandom_range(0, mg) : 0);
  endtask

  task automatic pulse_boot();
    boot_req = 1'b1;
    @(posedge clk); #1;
    boot_req = 1'b0;
  endtask

  // Returns the cycle number at which cpu_rst was first seen low, or -1.
  task automatic wait_run(output int fall);
    fall = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cpu_rst) begin fall = cyc; break; end
    end
    @(posedge clk); #1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    #2;
    n_cmp++;
    if ({cpu_rst, rom_we, rx_ready, busy, err} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctrl got cpu_rst/we/rdy/busy/err=%b want 10000",
               {cpu_rst, rom_we, rx_ready, busy, err});
    end
    n_cmp++;
    if (rom_addr !== '0 || rom_wdata !== 16'h0) begin
      n_err++;
      $display("FAIL reset_data got addr=%0h data=%0h want 0 0", rom_addr, rom_wdata);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({rx_ready, busy, cpu_rst, err} !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_release got rdy/busy/cpu_rst/err=%b want 1110", {rx_ready, busy, cpu_rst, err});
    end
  endtask

  task automatic test_basic();
    int fall;
    send_hdr(16'h0002, 0);
    send_word(0, 16'hEA10, 0);
    send_word(1, 16'hFC08, 0);
    wait_run(fall);
    n_cmp++;
    if (last_we_cyc - prev_we_cyc !== 3) begin
      n_err++;
      $display("FAIL basic_rate got %0d cycles/word want 3", last_we_cyc - prev_we_cyc);
    end
    // The WRITE cycle, then HOLD cycles of reset, then the first RUN cycle.
    n_cmp++;
    if (fall - last_we_cyc !== HOLD + 1) begin
      n_err++;
      $display("FAIL basic_hold got %0d want %0d", fall - last_we_cyc, HOLD + 1);
    end
    n_cmp++;
    if ({cpu_rst, busy, rx_ready, err, rom_we} !== 5'b00000) begin
      n_err++;
      $display("FAIL basic_run got cpu_rst/busy/rdy/err/we=%b want 00000", {cpu_rst, busy, rx_ready, err, rom_we});
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL basic_pending got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_zero_hdr();
    int fall;
    pulse_boot();
    send_hdr(16'h0000, 0);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if ({err, busy, rx_ready, cpu_rst} !== 4'b1001) begin
      n_err++;
      $display("FAIL zero_err got err/busy/rdy/cpu_rst=%b want 1001", {err, busy, rx_ready, cpu_rst});
    end
    pulse_boot();
    n_cmp++;
    if ({err, rx_ready, cpu_rst} !== 3'b011 || rom_addr !== '0) begin
      n_err++;
      $display("FAIL zero_restart got err/rdy/cpu_rst=%b addr=%0h want 011 0", {err, rx_ready, cpu_rst}, rom_addr);
    end
    send_hdr(16'h0001, 0);
    send_word(0, 16'h0007, 0);
    wait_run(fall);
    n_cmp++;
    if (fall < 0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL zero_reload got fall=%0d pending=%0d want run 0", fall, exp_q.size());
    end
  endtask

  task automatic test_size_limit();
    int fall;
    pulse_boot();
    send_hdr(16'((1 << AW) + 1), 0);
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL size_over_by_one got err=%0b want 1", err);
    end
    pulse_boot();
    send_hdr(16'h8001, 0);
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL size_8001 got err=%0b want 1", err);
    end
    pulse_boot();
    send_hdr(16'(1 << AW), 0);
    for (int i = 0; i < (1 << AW); i++)
      send_word(i, 16'(i * 16'h0123 + 16'h5A), 0);
    wait_run(fall);
    n_cmp++;
    if (fall < 0 || rom_addr !== AW'((1 << AW) - 1)) begin
      n_err++;
      $display("FAIL size_full got fall=%0d addr=%0h want run %0h", fall, rom_addr, (1 << AW) - 1);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL size_pending got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_gaps();
    int fall;
    for (int r = 0; r < 3; r++) begin
      pulse_boot();
      send_hdr(16'h0003, 5);
      for (int i = 0; i < 3; i++)
        send_word(i, 16'($urandom), 5);
      wait_run(fall);
      n_cmp++;
      if (fall < 0 || exp_q.size() !== 0) begin
        n_err++;
        $display("FAIL gaps_load got fall=%0d pending=%0d want run 0", fall, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_midload();
    int fall;
    pulse_boot();
    send_hdr(16'h0003, 0);
    send_byte(8'hAB, 0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({cpu_rst, rom_we, rx_ready, busy, err} !== 5'b10000 || rom_addr !== '0 || rom_wdata !== 16'h0) begin
      n_err++;
      $display("FAIL midload_reset got ctrl=%b addr=%0h data=%0h want 10000 0 0",
               {cpu_rst, rom_we, rx_ready, busy, err}, rom_addr, rom_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_hdr(16'h0001, 0);
    send_word(0, 16'h1234, 0);
    wait_run(fall);
    n_cmp++;
    if (fall < 0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL midload_reload got fall=%0d pending=%0d want run 0", fall, exp_q.size());
    end
  endtask

  task automatic test_boot_req();
    int fall;
    pulse_boot();
    send_hdr(16'h0002, 0);
    exp_q.push_back({AW'(0), 16'hC3A5});
    send_byte(8'hC3, 0);
    pulse_boot();            // lands in DATA_LO, must be ignored
    n_cmp++;
    if ({rx_ready, busy, err, cpu_rst} !== 4'b1101 || rom_wdata[15:8] !== 8'hC3) begin
      n_err++;
      $display("FAIL bootreq_ignored got rdy/busy/err/cpu_rst=%b hi=%0h want 1101 c3",
               {rx_ready, busy, err, cpu_rst}, rom_wdata[15:8]);
    end
    send_byte(8'hA5, 0);
    send_word(1, 16'h5A5A, 0);
    wait_run(fall);
    n_cmp++;
    if (fall < 0 || rom_addr !== AW'(1)) begin
      n_err++;
      $display("FAIL bootreq_first got fall=%0d addr=%0h want run 1", fall, rom_addr);
    end
    pulse_boot();
    n_cmp++;
    if ({cpu_rst, rx_ready} !== 2'b11 || rom_addr !== '0) begin
      n_err++;
      $display("FAIL bootreq_run got cpu_rst/rdy=%b addr=%0h want 11 0", {cpu_rst, rx_ready}, rom_addr);
    end
    send_hdr(16'h0001, 0);
    send_word(0, 16'hBEEF, 0);
    wait_run(fall);
    n_cmp++;
    if (fall < 0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL bootreq_reload got fall=%0d pending=%0d want run 0", fall, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_hdr();
    test_size_limit();
    test_gaps();
    test_reset_midload();
    test_boot_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
